// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and default geometry for the tree-PLRU set
//               controller. Holds default sizes, the per-set tree type, the
//               way and set index types, and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int unsigned c_NUM_SETS      = 64;
    localparam int unsigned c_ASSOCIATIVITY = 4;
    localparam int unsigned c_SET_BITS      = $clog2(c_NUM_SETS);
    localparam int unsigned c_WAY_BITS      = $clog2(c_ASSOCIATIVITY);

    // One tree-PLRU word per set: ASSOCIATIVITY-1 node bits, bit 0 is the root.
    typedef logic [c_ASSOCIATIVITY-2:0] plru_t;
    typedef logic [c_WAY_BITS-1:0]      way_t;
    typedef logic [c_SET_BITS-1:0]      set_idx_t;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/plru_tree.sv
`default_nettype none
// ============================================================================
// Module      : plru_tree
// Description : Combinational tree-PLRU helper. Given the node bits of one
//               set it returns the victim way, and given an accessed way it
//               returns the node bits with that way promoted to MRU.
//               Node 0 is the root; children of node i are 2i+1 and 2i+2.
//               A node bit of 0 points the victim into the lower half.
// Ports       : old_bits   in  current tree bits
//               access_way in  way being promoted
//               new_bits   out tree bits after promoting access_way
//               victim_way out way selected by following the tree bits
// Revision    : 1.0 - initial release
// ============================================================================
module plru_tree #(
    parameter  int unsigned ASSOCIATIVITY = 4,
    localparam int unsigned WAY_W         = $clog2(ASSOCIATIVITY),
    localparam int unsigned TREE_W        = ASSOCIATIVITY - 1
) (
    input  logic [TREE_W-1:0] old_bits,
    input  logic [WAY_W-1:0]  access_way,
    output logic [TREE_W-1:0] new_bits,
    output logic [WAY_W-1:0]  victim_way
);

    // Victim walk: each visited node bit becomes the next way bit, MSB first.
    always_comb begin : p_victim
        logic [WAY_W-1:0] w_node;
        logic             w_dir;
        victim_way = '0;
        w_node     = '0;
        for (int lvl = 0; lvl < int'(WAY_W); lvl++) begin
            w_dir                      = old_bits[w_node];
            victim_way[WAY_W-1-lvl]    = w_dir;
            w_node = (w_node << 1) + WAY_W'(1) + WAY_W'(w_dir);
        end
    end

    // Promotion: each node on the access path is pointed away from the
    // accessed half; nodes off the path keep their value.
    always_comb begin : p_update
        logic [WAY_W-1:0] w_node;
        logic             w_dir;
        new_bits = old_bits;
        w_node   = '0;
        for (int lvl = 0; lvl < int'(WAY_W); lvl++) begin
            w_dir            = access_way[WAY_W-1-lvl];
            new_bits[w_node] = ~w_dir;
            w_node = (w_node << 1) + WAY_W'(1) + WAY_W'(w_dir);
        end
    end

endmodule
`default_nettype wire

// File: rtl/plru_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : plru_set_ctrl
// Description : Per-set tree-PLRU state owner for an N-way set-associative
//               cache. Serves one lookup at a time: returns the hit way, the
//               lowest invalid way, or the PLRU victim, then promotes the
//               returned way to MRU when the response is consumed. Clears all
//               sets with a set-walking sequence after reset and on flush.
// Ports       : clk            in  clock
//               resetn         in  synchronous active-low reset
//               flush_req      in  pulse: clear all PLRU state
//               busy           out clear walk in progress
//               req_valid      in  lookup request valid
//               req_ready      out lookup request can be accepted
//               req_set        in  set index
//               req_hit        in  tag hit in this set
//               req_hit_way    in  hit way (ignored on miss)
//               req_valid_mask in  line-valid bits of the set
//               resp_valid     out response valid
//               resp_ready     in  response consumed
//               resp_set       out set of the held response
//               resp_way       out way to use (hit way or victim)
// Revision    : 1.0 - initial release
// ============================================================================
module plru_set_ctrl
    import cache_pkg::*;
#(
    parameter  int unsigned NUM_SETS      = c_NUM_SETS,
    parameter  int unsigned ASSOCIATIVITY = c_ASSOCIATIVITY,
    localparam int unsigned SET_W         = $clog2(NUM_SETS),
    localparam int unsigned WAY_W         = $clog2(ASSOCIATIVITY),
    localparam int unsigned TREE_W        = ASSOCIATIVITY - 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush_req,
    output logic                     busy,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [SET_W-1:0]         req_set,
    input  logic                     req_hit,
    input  logic [WAY_W-1:0]         req_hit_way,
    input  logic [ASSOCIATIVITY-1:0] req_valid_mask,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [SET_W-1:0]         resp_set,
    output logic [WAY_W-1:0]         resp_way
);

    localparam logic [SET_W-1:0] c_LAST_SET = SET_W'(NUM_SETS - 1);

    state_t             r_state;
    logic [SET_W-1:0]   r_walk_idx;
    logic               r_busy;
    logic               r_req_ready;
    logic               r_resp_valid;
    logic [SET_W-1:0]   r_resp_set;
    logic [WAY_W-1:0]   r_resp_way;
    logic [TREE_W-1:0]  r_table [NUM_SETS];

    logic [TREE_W-1:0]  w_tree_old;
    logic [TREE_W-1:0]  w_tree_new;
    logic [WAY_W-1:0]   w_victim;
    logic               w_has_invalid;
    logic [WAY_W-1:0]   w_first_invalid;
    logic [WAY_W-1:0]   w_sel_way;
    logic               w_handshake;

    // Single tree instance: in RESP it promotes the held way in the held set;
    // otherwise it reads the requested set to produce the victim. Only one
    // lookup is ever in flight, so sharing it is hazard-free.
    assign w_tree_old = (r_state == ST_RESP) ? r_table[r_resp_set] : r_table[req_set];

    plru_tree #(
        .ASSOCIATIVITY (ASSOCIATIVITY)
    ) u_plru_tree (
        .old_bits   (w_tree_old),
        .access_way (r_resp_way),
        .new_bits   (w_tree_new),
        .victim_way (w_victim)
    );

    // Lowest-index invalid way; scanning downward lets the lowest win.
    always_comb begin : p_first_invalid
        w_has_invalid   = 1'b0;
        w_first_invalid = '0;
        for (int i = int'(ASSOCIATIVITY) - 1; i >= 0; i--) begin
            if (!req_valid_mask[i]) begin
                w_has_invalid   = 1'b1;
                w_first_invalid = i[WAY_W-1:0];
            end
        end
    end

    always_comb begin : p_sel_way
        w_sel_way = w_victim;
        if (req_hit) begin
            w_sel_way = req_hit_way;
        end else if (w_has_invalid) begin
            w_sel_way = w_first_invalid;
        end
    end

    assign w_handshake = (r_state == ST_RESP) && resp_ready;

    // Control FSM. Reset outranks flush; flush outranks everything else, so a
    // pending response is dropped and a same-cycle request is not accepted.
    always_ff @(posedge clk) begin : p_fsm
        if (!resetn) begin
            r_state      <= ST_INIT;
            r_walk_idx   <= '0;
            r_busy       <= 1'b1;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_set   <= '0;
            r_resp_way   <= '0;
        end else if (flush_req) begin
            r_state      <= ST_INIT;
            r_walk_idx   <= '0;
            r_busy       <= 1'b1;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_walk_idx == c_LAST_SET) begin
                        r_state     <= ST_IDLE;
                        r_walk_idx  <= '0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_walk_idx  <= r_walk_idx + SET_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        r_state      <= ST_RESP;
                        r_resp_set   <= req_set;
                        r_resp_way   <= w_sel_way;
                        r_resp_valid <= 1'b1;
                        r_req_ready  <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_INIT;
                    r_walk_idx   <= '0;
                    r_busy       <= 1'b1;
                    r_req_ready  <= 1'b0;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // PLRU table: single write port shared by the clear walk and promotion.
    // No write happens in a reset or flush cycle.
    always_ff @(posedge clk) begin : p_table
        if (resetn && !flush_req) begin
            if (r_state == ST_INIT) begin
                r_table[r_walk_idx] <= '0;
            end else if (w_handshake) begin
                r_table[r_resp_set] <= w_tree_new;
            end
        end
    end

    assign busy       = r_busy;
    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_set   = r_resp_set;
    assign resp_way   = r_resp_way;

endmodule
`default_nettype wire
